bnn_cmd_sched: RTL and testbench

Command scheduler between the zero-riscy core and the BNN memory/compute block. It queues BNN commands pushed by the core and issues them on the shared BNN port, expanding repeat counts into address-stepped command sequences. It arbitrates that port against the core's ordinary data loads and stores, routes responses back to their owner, and captures activation results.

---
 rtl/bnn_cmd_sched.sv | 144 ++++++++++++++
 tb/tb_bnn_cmd_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_cmd_sched.sv
// BNN command scheduler: queues core-pushed BNN commands, expands repeats into
// address-stepped issues, and arbitrates the shared BNN port against core loads/stores.
module bnn_cmd_sched #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [3:0]  c_be,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        q_valid,
  output logic        q_ready,
  input  logic [12:0] q_addr,
  input  logic [3:0]  q_be,
  input  logic [31:0] q_wdata,
  input  logic [7:0]  q_rpt,
  input  logic        q_flush,
  output logic        m_b_req,
  output logic        m_p_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        act_valid,
  output logic [31:0] act_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  rpt;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, ACTW} state_e;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rcnt_q, rcnt_d;
  state_e        state_q, state_d;
  logic          core_prio_q, core_prio_d;
  logic          owner_core_q, owner_core_d;
  logic [31:0]   act_data_q, act_data_d;

  cmd_t        head;
  logic        full, bnn_pend, core_wins, p_gnt, b_gnt, pop, push, head_is_act;
  logic [12:0] seq_addr;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    full        = (count_q == (AW+1)'(DEPTH));
    bnn_pend    = (state_q == ISSUE);
    // Contested cycles alternate; core_prio_q remembers who lost the last one.
    core_wins   = c_req & (~bnn_pend | core_prio_q);
    p_gnt       = ~rst & m_gnt & c_req & core_wins;
    b_gnt       = ~rst & m_gnt & bnn_pend & ~core_wins;
    pop         = b_gnt & (rcnt_q == head.rpt);
    push        = q_valid & q_ready & ~q_flush;
    head_is_act = head.addr[12] & ~head.addr[8] & (head.addr[3:2] == 2'b11);
    seq_addr    = head.addr + (head.addr[12] ? 13'd0 : {3'b000, rcnt_q, 2'b00});
  end

  assign q_ready   = ~full | pop;
  assign c_gnt     = p_gnt;
  assign m_p_req   = p_gnt;
  assign m_b_req   = b_gnt;
  assign m_we      = p_gnt & c_we;
  assign m_be      = core_wins ? c_be : head.be;
  assign m_addr    = core_wins ? c_addr : {19'b0, seq_addr};
  assign m_wdata   = core_wins ? c_wdata : head.wdata;
  assign c_rvalid  = ~rst & m_rvalid & owner_core_q;
  assign c_rdata   = m_rdata;
  assign act_valid = (state_q == ACTW) & m_rvalid & ~owner_core_q;
  assign act_data  = act_data_q;
  assign busy      = ~rst & ((count_q != '0) | (state_q == ACTW) | ~m_gnt);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    rcnt_d       = rcnt_q;
    core_prio_d  = core_prio_q;
    owner_core_d = owner_core_q;
    act_data_d   = act_data_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (b_gnt) rcnt_d = pop ? '0 : rcnt_q + 8'd1;
    // Flush drops queued work but the command granted this cycle still goes out.
    if (q_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rcnt_d   = '0;
    end
    if (m_gnt & c_req & bnn_pend) core_prio_d = ~core_wins;
    if (p_gnt)      owner_core_d = 1'b1;
    else if (b_gnt) owner_core_d = 1'b0;
    if (act_valid) act_data_d = m_rdata;

    if (b_gnt & head_is_act)                    state_d = ACTW;
    else if ((state_q == ACTW) & ~act_valid)    state_d = ACTW;
    else                                        state_d = (count_d != '0) ? ISSUE : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rcnt_q       <= '0;
      state_q      <= IDLE;
      core_prio_q  <= 1'b1;
      owner_core_q <= 1'b0;
      act_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rcnt_q       <= rcnt_d;
      state_q      <= state_d;
      core_prio_q  <= core_prio_d;
      owner_core_q <= owner_core_d;
      act_data_q   <= act_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {q_addr, q_be, q_wdata, q_rpt};
  end

endmodule

// File: tb/tb_bnn_cmd_sched.sv
// Self-checking bench for bnn_cmd_sched: the bench plays the memory and keeps a
// queue-based model of command issue, arbitration and response ownership.
module tb_bnn_cmd_sched;

  localparam int DEPTH = 8;
  localparam int RK_ORPHAN = 0, RK_CORE = 1, RK_BNN = 2, RK_ACT = 3;

  typedef struct packed {
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  rpt;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we;
  logic [3:0]  c_be;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid;
  logic [31:0] c_rdata;
  logic        q_valid, q_ready;
  logic [12:0] q_addr;
  logic [3:0]  q_be;
  logic [31:0] q_wdata;
  logic [7:0]  q_rpt;
  logic        q_flush;
  logic        m_b_req, m_p_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  logic        busy, act_valid;
  logic [31:0] act_data;

  always #5 clk = ~clk;

  bnn_cmd_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .q_valid(q_valid), .q_ready(q_ready), .q_addr(q_addr), .q_be(q_be),
    .q_wdata(q_wdata), .q_rpt(q_rpt), .q_flush(q_flush),
    .m_b_req(m_b_req), .m_p_req(m_p_req), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .busy(busy), .act_valid(act_valid), .act_data(act_data)
  );

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, nb = 0, np = 0, nact = 0;
  cmd_t        mq[$];
  int          rep = 0;
  bit          core_next = 1'b1, act_wait = 1'b0, hold = 1'b0;
  int          stall = 0;
  int          r1_cyc = -1, r1_kind = 0, r2_cyc = -1, r2_kind = 0;
  logic [31:0] act_word = '0, exp_act_data = '0;

  function automatic bit is_act(input logic [12:0] a);
    return a[12] && !a[8] && (a[3:2] == 2'b11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: the memory drives the port, the model predicts every output,
  // then the model advances and time moves to just after the next edge.
  task automatic cycle();
    int rk;
    bit bp, e_b, e_p, popx, qr_e;
    cmd_t h;
    logic [12:0] a13;
    cyc++;
    m_gnt = (stall == 0) && !hold;
    rk = -1;
    if (r1_cyc == cyc) rk = r1_kind;
    if (r2_cyc == cyc) rk = r2_kind;
    m_rvalid = (rk >= 0);
    m_rdata  = (rk == RK_ACT) ? act_word : $urandom;
    #1;
    if (rst) begin
      chk("rst_c_gnt", 32'(c_gnt), 32'(0));
      chk("rst_m_b_req", 32'(m_b_req), 32'(0));
      chk("rst_m_p_req", 32'(m_p_req), 32'(0));
      chk("rst_c_rvalid", 32'(c_rvalid), 32'(0));
      chk("rst_act_valid", 32'(act_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_act_data", act_data, 32'(0));
      chk("rst_q_ready", 32'(q_ready), 32'(1));
      mq.delete();
      rep = 0; core_next = 1'b1; act_wait = 1'b0; exp_act_data = '0;
      if (r1_cyc > cyc) r1_kind = RK_ORPHAN;
      if (r2_cyc > cyc) r2_kind = RK_ORPHAN;
    end else begin
      bp  = (mq.size() > 0) && !act_wait;
      e_p = 1'b0; e_b = 1'b0;
      if (m_gnt) begin
        if (c_req && bp) begin
          e_p = core_next; e_b = !core_next; core_next = !core_next;
        end else begin
          e_p = c_req; e_b = bp;
        end
      end
      popx = e_b && (rep == int'(mq[0].rpt));
      qr_e = (mq.size() < DEPTH) || popx;
      chk("m_p_req", 32'(m_p_req), 32'(e_p));
      chk("m_b_req", 32'(m_b_req), 32'(e_b));
      chk("c_gnt", 32'(c_gnt), 32'(e_p));
      chk("busy", 32'(busy), 32'((mq.size() > 0) || act_wait || !m_gnt));
      chk("q_ready", 32'(q_ready), 32'(qr_e));
      chk("c_rvalid", 32'(c_rvalid), 32'(rk == RK_CORE));
      chk("act_valid", 32'(act_valid), 32'(rk == RK_ACT));
      chk("c_rdata", c_rdata, m_rdata);
      chk("act_data", act_data, exp_act_data);
      if (stall > 0) stall--;
      if (e_p) begin
        chk("core_addr", m_addr, c_addr);
        chk("core_we", 32'(m_we), 32'(c_we));
        chk("core_be", 32'(m_be), 32'(c_be));
        chk("core_wdata", m_wdata, c_wdata);
        r1_cyc = cyc + 1; r1_kind = RK_CORE; np++;
      end
      if (e_b) begin
        h   = mq[0];
        a13 = h.addr + (h.addr[12] ? 13'd0 : 13'(rep * 4));
        chk("bnn_addr", m_addr, {19'b0, a13});
        chk("bnn_we", 32'(m_we), 32'(0));
        chk("bnn_be", 32'(m_be), 32'(h.be));
        chk("bnn_wdata", m_wdata, h.wdata);
        nb++;
        if (is_act(h.addr)) begin
          act_wait = 1'b1; r2_cyc = cyc + 2; r2_kind = RK_ACT;
        end else if (!h.addr[12]) begin
          stall = 3;
        end else begin
          r1_cyc = cyc + 1; r1_kind = RK_BNN;
        end
        if (popx) begin
          void'(mq.pop_front());
          rep = 0;
        end else begin
          rep++;
        end
      end
      if (rk == RK_ACT) begin
        exp_act_data = m_rdata; act_wait = 1'b0; nact++;
      end
      if (q_flush) begin
        mq.delete(); rep = 0;
      end else if (q_valid && qr_e) begin
        h = {q_addr, q_be, q_wdata, q_rpt};
        mq.push_back(h);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input logic [12:0] a, input logic [3:0] be, input logic [7:0] rpt);
    q_valid = 1'b1; q_addr = a; q_be = be; q_rpt = rpt; q_wdata = $urandom;
  endtask

  initial begin
    rst = 1'b1; c_req = 1'b0; c_we = 1'b0; c_be = '0; c_addr = '0; c_wdata = '0;
    q_valid = 1'b0; q_addr = '0; q_be = '0; q_wdata = '0; q_rpt = '0; q_flush = 1'b0;
    m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    @(posedge clk); #1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Accumulate row with three repeats: four issues stepping by one row.
    set_cmd(13'h000, 4'hF, 8'd3); cycle(); q_valid = 1'b0;
    nb = 0;
    repeat (20) cycle();
    chk("acc_issues", 32'(nb), 32'(4));
    chk("acc_busy_after", 32'(busy), 32'(0));

    // Fill past capacity with the port stalled, then drain.
    hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_cmd(13'h1000 | 13'(i << 4), 4'h1, 8'd0); cycle();
    end
    q_valid = 1'b0;
    chk("full_q_ready", 32'(q_ready), 32'(0));
    hold = 1'b0; nb = 0;
    repeat (10) cycle();
    chk("drain_issues", 32'(nb), 32'(8));

    // Core held against single-cycle commands: first contest to the core, then alternate.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(13'h1100 | 13'(i << 4), 4'h3, 8'd1); cycle();
    end
    q_valid = 1'b0; hold = 1'b0; nb = 0; np = 0; c_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      c_we = 1'($urandom); c_be = 4'($urandom); c_addr = $urandom; c_wdata = $urandom;
      cycle();
    end
    c_req = 1'b0;
    chk("alt_bnn_issues", 32'(nb), 32'(6));
    chk("alt_core_grants", 32'(np), 32'(6));
    repeat (3) cycle();

    // Activation with a command queued behind it.
    act_word = 32'hA5A5_0F0F; nact = 0;
    set_cmd(13'h100C, 4'hF, 8'd0); cycle();
    set_cmd(13'h1010, 4'h1, 8'd0); cycle();
    q_valid = 1'b0;
    repeat (6) cycle();
    chk("act_count", 32'(nact), 32'(1));
    chk("act_data_val", act_data, 32'hA5A5_0F0F);

    // Flush in the same cycle as the first grant; a simultaneous push is dropped.
    hold = 1'b1;
    set_cmd(13'h040, 4'hF, 8'd2); cycle();
    set_cmd(13'h1010, 4'h1, 8'd0); cycle();
    set_cmd(13'h1020, 4'h1, 8'd0); cycle();
    hold = 1'b0; q_flush = 1'b1; set_cmd(13'h1030, 4'h1, 8'd0); nb = 0;
    cycle();
    q_flush = 1'b0; q_valid = 1'b0;
    repeat (8) cycle();
    chk("flush_issues", 32'(nb), 32'(1));
    set_cmd(13'h080, 4'h7, 8'd1); cycle(); q_valid = 1'b0; nb = 0;
    repeat (12) cycle();
    chk("post_flush_issues", 32'(nb), 32'(2));

    // Reset one cycle after an activation grant; its late response must be ignored.
    set_cmd(13'h1E0C, 4'hF, 8'd0); cycle(); q_valid = 1'b0;
    nact = 0;
    cycle();
    rst = 1'b1; c_req = 1'b1; cycle();
    rst = 1'b0; c_req = 1'b0;
    repeat (4) cycle();
    chk("orphan_act", 32'(nact), 32'(0));

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      act_word = $urandom;
      hold     = ($urandom_range(0, 7) == 0);
      q_flush  = ($urandom_range(0, 49) == 0);
      q_valid  = ($urandom_range(0, 2) == 0);
      q_be     = 4'($urandom);
      q_wdata  = $urandom;
      case ($urandom_range(0, 3))
        0:       begin q_addr = {1'b0, 12'($urandom)}; q_rpt = 8'($urandom_range(0, 3)); end
        1:       begin q_addr = {1'b1, 12'($urandom)}; q_rpt = 8'($urandom_range(0, 2)); end
        2:       begin q_addr = {1'b1, 3'($urandom), 1'b0, 6'($urandom), 2'b11}; q_rpt = 8'($urandom_range(0, 1)); end
        default: begin q_addr = {1'b1, 3'($urandom), 1'b1, 6'($urandom), 2'b11}; q_rpt = 8'd0; end
      endcase
      c_req   = !act_wait && ($urandom_range(0, 1) == 1);
      c_we    = 1'($urandom);
      c_be    = 4'($urandom);
      c_addr  = $urandom;
      c_wdata = $urandom;
      cycle();
    end
    q_valid = 1'b0; q_flush = 1'b0; c_req = 1'b0; hold = 1'b0;
    repeat (40) cycle();
    chk("final_idle_busy", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
